trisc_mem_arbiter: RTL

- Sequences and shares the single TRISC program/data RAM between two requesters: the CPU controller and the I/O program loader.
- One requester is granted at a time, and ties are broken round-robin.
- The block drives the RAM control for a fixed WAIT_CYCLES access, captures read data, then returns a one-cycle Ack to the granted requester.
- It sits between the controller/loader and the RAM.

---
 rtl/trisc_mem_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/trisc_mem_arbiter.sv
// trisc_mem_arbiter
//   Shares the single TRISC program/data RAM between the CPU controller and
//   the I/O program loader. One requester owns the RAM per transaction and
//   ties are broken round-robin. Each transaction drives the RAM for
//   WAIT_CYCLES cycles, captures read data, and then pulses a one-cycle Ack
//   to the owner. All state updates happen on the falling edge of SysClock.
//
// Ports:
//   SysClock, Reset                  clock (falling-edge active), async active-high reset
//   CpuReq/CpuWe/CpuAddr/CpuWData    CPU request, held until CpuAck
//   CpuAck                           one-cycle completion pulse to the CPU
//   LdReq/LdWe/LdAddr/LdWData        loader request, held until LdAck
//   LdAck                            one-cycle completion pulse to the loader
//   RData                            last captured read data
//   MemEn/MemWe/MemAddr/MemWData     RAM control, held stable during the access
//   MemRData                         RAM read data
//   GntOwner                         current/last owner (0 = CPU, 1 = loader)
//   Busy                             high while a transaction is in progress
module trisc_mem_arbiter #(
    parameter int AW          = 4,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          SysClock,
    input  logic          Reset,
    input  logic          CpuReq,
    input  logic          CpuWe,
    input  logic [AW-1:0] CpuAddr,
    input  logic [DW-1:0] CpuWData,
    output logic          CpuAck,
    input  logic          LdReq,
    input  logic          LdWe,
    input  logic [AW-1:0] LdAddr,
    input  logic [DW-1:0] LdWData,
    output logic          LdAck,
    output logic [DW-1:0] RData,
    output logic          MemEn,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    output logic          GntOwner,
    output logic          Busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t     state;
    logic       last_gnt;
    logic [3:0] wait_cnt;
    logic       pick_ld;

    // Loader wins when it is the only requester, or on a tie when the CPU
    // was the last owner.
    always_comb begin
        pick_ld = LdReq && (!CpuReq || !last_gnt);
    end

    always_ff @(negedge SysClock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            wait_cnt <= '0;
            CpuAck   <= 1'b0;
            LdAck    <= 1'b0;
            MemEn    <= 1'b0;
            MemWe    <= 1'b0;
            Busy     <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            RData    <= '0;
            GntOwner <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CpuReq || LdReq) begin
                        state    <= ACCESS;
                        MemAddr  <= pick_ld ? LdAddr   : CpuAddr;
                        MemWData <= pick_ld ? LdWData  : CpuWData;
                        MemWe    <= pick_ld ? LdWe     : CpuWe;
                        MemEn    <= 1'b1;
                        Busy     <= 1'b1;
                        GntOwner <= pick_ld;
                        last_gnt <= pick_ld;
                        wait_cnt <= 4'(WAIT_CYCLES - 1);
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        state  <= DONE;
                        MemEn  <= 1'b0;
                        MemWe  <= 1'b0;
                        // MemWe still holds the latched direction here.
                        if (!MemWe) begin
                            RData <= MemRData;
                        end
                        CpuAck <= !GntOwner;
                        LdAck  <= GntOwner;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    CpuAck <= 1'b0;
                    LdAck  <= 1'b0;
                    Busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
